// File: rtl/regfile_mp.sv
// regfile_mp: parametrised 2R1W register file with zero entry, bypass and sweep clear
// Ports: clk, reset_n (async active-low); rg_wrt_en/addr/data write port;
//   rg_rd_addr1/2 -> rg_rd_data1/2 combinational reads; clr_req starts a sweep,
//   clr_busy/clr_done/wr_rej report sweep status.
// Option REGFILE_MP_PARITY_EN: adds perr_inj input and rd_perr1/rd_perr2 outputs.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rg_wrt_en,
  input  logic [ADDR_W-1:0] rg_wrt_addr,
  input  logic [DATA_W-1:0] rg_wrt_data,
  input  logic [ADDR_W-1:0] rg_rd_addr1,
  input  logic [ADDR_W-1:0] rg_rd_addr2,
  output logic [DATA_W-1:0] rg_rd_data1,
  output logic [DATA_W-1:0] rg_rd_data2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_rej
`ifdef REGFILE_MP_PARITY_EN
  ,
  input  logic              perr_inj,
  output logic              rd_perr1,
  output logic              rd_perr2
`endif
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic wr_acc, last, zero1, zero2, byp1, byp2;
  // reset_n gates acceptance so nothing is forwarded while the array is held clear
  assign wr_acc = reset_n && rg_wrt_en && state == IDLE && !(ZERO_REG != 0 && rg_wrt_addr == '0);
  assign last = state == CLEAR && ptr == ADDR_W'(DEPTH - 1);
  assign clr_busy = state == CLEAR;
  assign zero1 = ZERO_REG != 0 && rg_rd_addr1 == '0;
  assign zero2 = ZERO_REG != 0 && rg_rd_addr2 == '0;
  assign byp1 = BYPASS != 0 && wr_acc && rg_wrt_addr == rg_rd_addr1;
  assign byp2 = BYPASS != 0 && wr_acc && rg_wrt_addr == rg_rd_addr2;
  assign rg_rd_data1 = zero1 ? '0 : byp1 ? rg_wrt_data : mem[rg_rd_addr1];
  assign rg_rd_data2 = zero2 ? '0 : byp2 ? rg_wrt_data : mem[rg_rd_addr2];
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (clr_req ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
      wr_rej   <= 1'b0;
      mem      <= '0;
    end else begin
      state    <= state_nx;
      clr_done <= last;
      wr_rej   <= rg_wrt_en && state == CLEAR;
      ptr      <= state == CLEAR ? ptr + 1'b1 : '0;
      if (state == CLEAR) mem[ptr] <= '0;
      else if (wr_acc) mem[rg_wrt_addr] <= rg_wrt_data;
    end
  end
`ifdef REGFILE_MP_PARITY_EN
  logic [DEPTH-1:0] par;
  assign rd_perr1 = !zero1 && !byp1 && (par[rg_rd_addr1] != ^mem[rg_rd_addr1]);
  assign rd_perr2 = !zero2 && !byp2 && (par[rg_rd_addr2] != ^mem[rg_rd_addr2]);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par <= '0;
    else if (state == CLEAR) par[ptr] <= 1'b0;
    else if (wr_acc) par[rg_wrt_addr] <= ^rg_wrt_data ^ perr_inj;
  end
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default and bypass builds)
module tb_regfile_mp;
  logic clk, reset_n, rg_wrt_en, clr_req;
  logic [4:0] rg_wrt_addr, rg_rd_addr1, rg_rd_addr2;
  logic [31:0] rg_wrt_data;
  logic [31:0] rd1, rd2, rd1_b, rd2_b;
  logic busy, done, rej, busy_b, done_b, rej_b;
  int checks = 0;
  int errors = 0;
  int busy_cnt, done_cnt;
`ifdef REGFILE_MP_PARITY_EN
  logic perr_inj, perr1, perr2, perr1_b, perr2_b;
`endif
  regfile_mp dut (
    .clk(clk), .reset_n(reset_n), .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr),
    .rg_wrt_data(rg_wrt_data), .rg_rd_addr1(rg_rd_addr1), .rg_rd_addr2(rg_rd_addr2),
    .rg_rd_data1(rd1), .rg_rd_data2(rd2), .clr_req(clr_req), .clr_busy(busy),
    .clr_done(done), .wr_rej(rej)
`ifdef REGFILE_MP_PARITY_EN
    , .perr_inj(perr_inj), .rd_perr1(perr1), .rd_perr2(perr2)
`endif
  );
  regfile_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr),
    .rg_wrt_data(rg_wrt_data), .rg_rd_addr1(rg_rd_addr1), .rg_rd_addr2(rg_rd_addr2),
    .rg_rd_data1(rd1_b), .rg_rd_data2(rd2_b), .clr_req(clr_req), .clr_busy(busy_b),
    .clr_done(done_b), .wr_rej(rej_b)
`ifdef REGFILE_MP_PARITY_EN
    , .perr_inj(perr_inj), .rd_perr1(perr1_b), .rd_perr2(perr2_b)
`endif
  );
  initial begin
    clk = 0;
    #20;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rg_wrt_en = 1; rg_wrt_addr = a; rg_wrt_data = d;
    step();
    rg_wrt_en = 0;
  endtask
  initial begin
    reset_n = 0; rg_wrt_en = 1; rg_wrt_addr = 1; rg_wrt_data = 32'hFFFF_FFFF;
    rg_rd_addr1 = 1; rg_rd_addr2 = 31; clr_req = 0;
`ifdef REGFILE_MP_PARITY_EN
    perr_inj = 0;
`endif
    #1;
    chk("rst_rd1", rd1, 0);
    chk("rst_rd2", rd2, 0);
    chk("rst_rd1_byp", rd1_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rej", rej, 0);
    #10;
    chk("rst10_rd1", rd1, 0);
    chk("rst10_rd2", rd2, 0);
    reset_n = 1;
    #1;
    chk("byp_pre_w1", rd1_b, 32'hFFFF_FFFF);
    chk("nobyp_pre_w1", rd1, 0);
    step();
    chk("wr1_rd1", rd1, 32'hFFFF_FFFF);
    rg_wrt_addr = 0; rg_wrt_data = 32'h1234_5678; rg_rd_addr2 = 0;
    #1;
    chk("byp_zero_rd2", rd2_b, 0);
    step();
    rg_wrt_en = 0;
    #1;
    chk("zero_rd2", rd2, 0);
    chk("zero_rd2_b", rd2_b, 0);
    chk("zero_no_rej", rej, 0);
    chk("keep_rd1", rd1, 32'hFFFF_FFFF);
    rg_wrt_en = 1; rg_wrt_addr = 5; rg_wrt_data = 32'hA5A5_A5A5; rg_rd_addr1 = 5;
    #1;
    chk("nobyp_pre5", rd1, 0);
    chk("byp_pre5", rd1_b, 32'hA5A5_A5A5);
    step();
    rg_wrt_en = 0;
    #1;
    chk("nobyp_post5", rd1, 32'hA5A5_A5A5);
    chk("byp_post5", rd1_b, 32'hA5A5_A5A5);
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    rg_rd_addr1 = 7; rg_rd_addr2 = 31;
    #1;
    chk("fill7", rd1, 7);
    chk("fill31", rd2, 31);
    clr_req = 1;
    step();
    clr_req = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (k == 32) chk("done_at_end", done, 1);
      if (k == 10) begin
        rg_rd_addr1 = 9; rg_rd_addr2 = 10;
        #1;
        chk("swept9", rd1, 0);
        chk("unswept10", rd2, 10);
        rg_wrt_en = 1; rg_wrt_addr = 20; rg_wrt_data = 32'hDEAD_BEEF; clr_req = 1;
      end
      if (k == 11) begin
        chk("rej_pulse", rej, 1);
        rg_wrt_en = 0; clr_req = 0; rg_rd_addr1 = 20;
        #1;
        chk("rej_nochange", rd1, 20);
      end
      if (k == 12) chk("rej_one", rej, 0);
      step();
    end
    chk("busy_cycles", busy_cnt, 32);
    chk("done_pulses", done_cnt, 1);
    for (int i = 0; i < 32; i += 2) begin
      rg_rd_addr1 = 5'(i); rg_rd_addr2 = 5'(i + 1);
      #1;
      chk("swept_rd1", rd1, 0);
      chk("swept_rd2", rd2, 0);
    end
    wr(20, 77);
    rg_wrt_en = 1; rg_wrt_addr = 4; rg_wrt_data = 44; clr_req = 1;
    step();
    rg_wrt_en = 0; clr_req = 0; rg_rd_addr1 = 4; rg_rd_addr2 = 20;
    #1;
    chk("wr_then_clr", rd1, 44);
    chk("clr_busy_start", busy, 1);
    for (int k = 0; k < 7; k++) step();
    chk("pre_rst_rd2", rd2, 77);
    chk("pre_rst_rd1", rd1, 0);
    #2;
    reset_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rd2", rd2, 0);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done) done_cnt++;
    end
    reset_n = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done || busy) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
`ifdef REGFILE_MP_PARITY_EN
    perr_inj = 1; rg_rd_addr1 = 3;
    wr(3, 1);
    perr_inj = 0;
    #1;
    chk("perr_inj", perr1, 1);
    wr(3, 1);
    #1;
    chk("perr_clear", perr1, 0);
    chk("perr_data", rd1, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the 32x32 register file: configurable width and depth, two combinational read ports, one synchronous write port, and an asynchronous active-low reset that clears all entries. Adds three things: an optional hard-wired zero entry, optional write-to-read bypass, and a clear engine that zeroes the array one entry per cycle on request. Sits in the CPU datapath between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, width of each entry in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 0, 1 = an accepted same-cycle write to the read address is forwarded to that read port

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
rg_wrt_en  in  1  write enable
rg_wrt_addr  in  ADDR_W  write address
rg_wrt_data  in  DATA_W  write data
rg_rd_addr1  in  ADDR_W  read port 1 address
rg_rd_addr2  in  ADDR_W  read port 2 address
rg_rd_data1  out  DATA_W  read port 1 data, combinational
rg_rd_data2  out  DATA_W  read port 2 data, combinational
clr_req  in  1  single-cycle pulse; starts a clear sweep
clr_busy  out  1  high while a sweep is in progress
clr_done  out  1  one-cycle pulse on the final sweep write
wr_rej  out  1  one-cycle pulse when a write is dropped during a sweep

Behaviour:
- Reset (reset_n=0): immediately, independent of clk, all entries = 0, FSM = IDLE, sweep pointer = 0, clr_busy = clr_done = wr_rej = 0.
  - Read outputs are therefore 0 during reset for any address.
  - While reset_n=0, writes and clr_req are ignored.
- Reads: rg_rd_dataN = mem[rg_rd_addrN], combinational, no clock dependency.
  - ZERO_REG=1: address 0 reads 0.
  - Both ports may read the same address.
- Write: on a rising clk edge with reset_n=1, rg_wrt_en=1 and FSM=IDLE, mem[rg_wrt_addr] <= rg_wrt_data.
  - Data is visible on reads after that edge.
  - ZERO_REG=1 and addr=0: the write is discarded silently, with no wr_rej pulse.
- Bypass (BYPASS=1):
  - Condition: write accepted this cycle, rg_wrt_addr == rg_rd_addrN, and the address is not a zero entry.
  - Effect: rg_rd_dataN = rg_wrt_data combinationally, in the same cycle.
  - BYPASS=0: reads return the old value until the edge.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on a clk edge with clr_req=1; pointer <= 0.
  - In CLEAR, each edge: mem[pointer] <= 0, pointer++.
  - On the edge that writes entry DEPTH-1: clr_done pulses for the following cycle, FSM -> IDLE, pointer -> 0.
  - clr_busy is high for exactly DEPTH cycles per sweep; the next clr_req is accepted on the cycle after clr_done.
- Simultaneous events:
  - clr_req and rg_wrt_en high in IDLE on the same edge: the write completes, then the sweep starts. The written entry is later cleared.
  - rg_wrt_en=1 while in CLEAR: the write is dropped and wr_rej pulses for the cycle after that edge.
  - clr_req while in CLEAR is ignored; no restart.
  - Reads during CLEAR return live contents: swept entries read 0, unswept entries keep their old data.
- Reset mid-sweep: the array clears at once and the FSM returns to IDLE. No clr_done is issued.
- Address wrap: the pointer is ADDR_W bits. Terminal detection uses pointer == DEPTH-1, so the pointer never overflows into a second pass.

Optional Feature:
Macro: REGFILE_MP_PARITY_EN
- Defined:
  - Each entry stores one extra even-parity bit, computed from rg_wrt_data on write.
  - New input perr_inj (1 bit): when high on an accepted write, the stored parity bit is inverted.
  - New outputs rd_perr1 and rd_perr2, combinational: high when the stored parity of the read entry mismatches its data.
  - Bypassed reads and zero entries report no error.
  - Reset and sweep writes store data 0 with parity 0.
- Not defined: no parity storage, no perr_inj / rd_perr ports, behaviour otherwise identical.

Test Plan:
1. reset_n=0 with rd_addr1=1, rd_addr2=31, wrt_en=1, data=FFFFFFFF -> both reads 0; check again 10 ns into reset with no clk edge -> still 0.
2. Release reset; write addr 1 = FFFFFFFF, then addr 0 = 12345678 (ZERO_REG=1) -> rd1(addr 1) = FFFFFFFF; rd2(addr 0) = 0.
3. BYPASS=1: write addr 5 = A5A5A5A5 with rd_addr1=5 -> rd1 = A5A5A5A5 before the edge. BYPASS=0: rd1 = 0 before the edge and A5A5A5A5 after it.
4. Fill addrs 1..31 with the address value, pulse clr_req -> clr_busy high 32 cycles; clr_done one pulse; all reads 0; a write at sweep cycle 10 -> wr_rej pulse and no data change.
5. Start a sweep, assert reset_n=0 at sweep cycle 7 -> clr_busy drops asynchronously, all reads 0, no clr_done pulse.
6. REGFILE_MP_PARITY_EN: write addr 3 = 00000001 with perr_inj=1 -> rd_perr1 = 1 at rd_addr1=3; rewrite with perr_inj=0 -> rd_perr1 = 0.
